instr_fetch: RTL
================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the byte address of the first fetch after reset.
REQ-002 The block SHALL use one clock, clk; reset is rst_n, asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 imem_req  output  1  instruction memory read request.
REQ-006 imem_addr  output  32  word-aligned fetch address (equals pc).
REQ-007 imem_ack  input  1  memory has returned imem_rdata this cycle.
REQ-008 imem_rdata  input  32  fetched instruction word, valid only with imem_ack.
REQ-009 redirect  input  1  branch taken; next fetch comes from redirect_target.
REQ-010 redirect_target  input  32  branch target byte address.
REQ-011 dec_valid  output  1  instruction on instr/op/funct valid for the decoder.
REQ-012 dec_ready  input  1  decoder consumes the instruction this cycle.
REQ-013 instr  output  32  registered instruction word.
REQ-014 op  output  6  instr[31:26], feeds the control unit Op input.
REQ-015 funct  output  6  instr[5:0], feeds the control unit Funct input.
REQ-016 pc_plus4  output  32  address of the held instruction plus 4.

Function
REQ-017 FSM states SHALL be IDLE, REQ, HOLD.
REQ-018 IDLE SHALL go to REQ unconditionally on the next clock.
REQ-019 In REQ, imem_req=1 and imem_addr=pc; state holds until imem_ack.
REQ-020 On imem_ack in REQ with no pending flush: instr<=imem_rdata, pc_plus4<=pc+4, pc<=pc+4, go HOLD; dec_valid rises the following cycle (latency 1 from ack).
REQ-021 In HOLD, dec_valid=1, imem_req=0; instr, op, funct, pc_plus4 SHALL stay stable until dec_ready.
REQ-022 HOLD with dec_ready: go REQ; imem_req asserts the next cycle.
REQ-023 HOLD with dec_ready and redirect in the same cycle: pc<=redirect_target with bits [1:0] forced to 0, go REQ.
REQ-024 redirect in HOLD without dec_ready SHALL be ignored.
REQ-025 redirect in REQ without imem_ack: set flush flag, latch target; the next ack's data is discarded, pc<=latched target, stay REQ, flush clears.
REQ-026 redirect in REQ coincident with imem_ack: data discarded, pc<=redirect_target, stay REQ.
REQ-027 A second redirect while flush is set SHALL overwrite the latched target.
REQ-028 redirect in IDLE SHALL set pc to the target; fetch in REQ uses it.
REQ-029 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0).
REQ-030 imem_ack outside REQ SHALL be ignored.

Reset
REQ-031 While rst_n=0: state=IDLE, pc=RESET_PC, flush=0, imem_req=0, dec_valid=0, instr=0, op=0, funct=0, pc_plus4=0.
REQ-032 Reset asserted mid-REQ or mid-HOLD SHALL abort immediately; an ack arriving during reset is discarded.

Configuration
REQ-033 Macro FETCH_PERF_CNT_EN, when defined, adds output fetch_count (32 bits): reset 0, incremented on each REQ->HOLD transition, wraps at 2^32; discarded fetches not counted.
REQ-034 Without FETCH_PERF_CNT_EN, the port and counter SHALL not exist.

Structure
REQ-035 Package mips_pkg SHALL hold the fetch state enum, word width 32, and opcode constants OP_RTYPE 6'b000000, OP_LW 6'b100011, OP_SW 6'b101011, OP_BEQ 6'b000100.
REQ-036 One sub-module, pc_reg, SHALL hold the PC with async reset to RESET_PC and load-enable/next-value inputs.

Verification
REQ-037 Reset release, ack after 2 cycles with 32'h8C08_0004 -> imem_addr 0, dec_valid next cycle, op 6'b100011, pc_plus4 4.
REQ-038 HOLD with dec_ready=0 for 3 cycles -> instr stable, no imem_req; dec_ready=1 -> imem_req next cycle at addr 4.
REQ-039 dec_ready+redirect target 32'h0000_0043 -> next imem_addr 32'h0000_0040.
REQ-040 redirect to 32'h100 in REQ, ack 2 cycles later -> data dropped, dec_valid stays 0, next imem_addr 32'h100.
REQ-041 RESET_PC=32'hFFFF_FFFC, one fetch -> pc_plus4 0, next imem_addr 0.
REQ-042 rst_n low mid-REQ with ack -> all outputs 0, restart at RESET_PC; with FETCH_PERF_CNT_EN, 5 fetches plus 1 flushed -> fetch_count 5.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the fetch front end.
//   fetch_state_e  fetch FSM state encoding (IDLE, REQ, HOLD)
//   WORD_W         datapath / address width
//   OP_*           primary opcode values seen on instr[31:26]
//   word_align()   clears the byte-offset bits of an address
package mips_pkg;

   localparam int unsigned WORD_W = 32;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      HOLD
   } fetch_state_e;

   function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] addr);
      return {addr[WORD_W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/pc_reg.sv
// pc_reg: program counter register.
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset, loads RESET_PC
//   load     when high, pc takes next_pc on the next edge
//   next_pc  value to load
//   pc       current program counter
import mips_pkg::*;

module pc_reg #(
   parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [WORD_W-1:0] next_pc,
   output logic [WORD_W-1:0] pc
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc <= RESET_PC;
      end else if (load) begin
         pc <= next_pc;
      end
   end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: single-outstanding instruction fetch stage with redirect/flush handling.
//   clk, rst_n               clock, asynchronous active-low reset
//   imem_req, imem_addr      memory read request and word address (imem_addr == pc)
//   imem_ack, imem_rdata     memory response; data valid only with ack
//   redirect, redirect_target  taken-branch redirect and its byte address
//   dec_valid, dec_ready     handshake towards the decoder
//   instr, op, funct         held instruction word and its opcode/function fields
//   pc_plus4                 address of the held instruction plus 4
//   fetch_count              accepted fetches (only when FETCH_PERF_CNT_EN is defined)
import mips_pkg::*;

module instr_fetch #(
   parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              imem_req,
   output logic [WORD_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [WORD_W-1:0] imem_rdata,
   input  logic              redirect,
   input  logic [WORD_W-1:0] redirect_target,
   output logic              dec_valid,
   input  logic              dec_ready,
   output logic [WORD_W-1:0] instr,
   output logic [5:0]        op,
   output logic [5:0]        funct,
   output logic [WORD_W-1:0] pc_plus4
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [WORD_W-1:0] fetch_count
`endif
);

   fetch_state_e      state_q;
   logic              flush_q;
   logic [WORD_W-1:0] flush_target_q;
   logic [WORD_W-1:0] pc;
   logic              pc_load;
   logic [WORD_W-1:0] pc_next;
   logic              fetch_accept;

   // A response is kept only if no redirect is pending or arriving with it.
   assign fetch_accept = (state_q == REQ) && imem_ack && !redirect && !flush_q;

   assign imem_addr = pc;
   assign op        = instr[31:26];
   assign funct     = instr[5:0];

   always_comb begin
      pc_load = 1'b0;
      pc_next = pc;
      case (state_q)
         IDLE: begin
            if (redirect) begin
               pc_load = 1'b1;
               pc_next = word_align(redirect_target);
            end
         end
         REQ: begin
            // pc stays put while a request is outstanding; it moves only on ack.
            if (imem_ack) begin
               pc_load = 1'b1;
               if (redirect) begin
                  pc_next = word_align(redirect_target);
               end else if (flush_q) begin
                  pc_next = flush_target_q;
               end else begin
                  pc_next = pc + 32'd4;
               end
            end
         end
         HOLD: begin
            if (dec_ready && redirect) begin
               pc_load = 1'b1;
               pc_next = word_align(redirect_target);
            end
         end
         default: ;
      endcase
   end

   pc_reg #(
      .RESET_PC(RESET_PC)
   ) u_pc_reg (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (pc_load),
      .next_pc(pc_next),
      .pc     (pc)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         flush_q        <= 1'b0;
         flush_target_q <= '0;
         imem_req       <= 1'b0;
         dec_valid      <= 1'b0;
         instr          <= '0;
         pc_plus4       <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               state_q  <= REQ;
               imem_req <= 1'b1;
            end
            REQ: begin
               if (fetch_accept) begin
                  instr     <= imem_rdata;
                  pc_plus4  <= pc + 32'd4;
                  dec_valid <= 1'b1;
                  imem_req  <= 1'b0;
                  state_q   <= HOLD;
               end else if (imem_ack) begin
                  // Discarded response: refetch from the redirect target.
                  flush_q <= 1'b0;
               end else if (redirect) begin
                  flush_q        <= 1'b1;
                  flush_target_q <= word_align(redirect_target);
               end
            end
            HOLD: begin
               if (dec_ready) begin
                  dec_valid <= 1'b0;
                  imem_req  <= 1'b1;
                  state_q   <= REQ;
               end
            end
            default: begin
               state_q   <= IDLE;
               imem_req  <= 1'b0;
               dec_valid <= 1'b0;
            end
         endcase
      end
   end

`ifdef FETCH_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_count <= '0;
      end else if (fetch_accept) begin
         fetch_count <= fetch_count + 32'd1;
      end
   end
`else
   // No performance counter in this build.
`endif

endmodule
